// File: rtl/unidade_busca.sv
// Instruction fetch unit: requests words from instruction memory, holds them for decode, computes next PC.
// Optional macro BUSCA_CONTADOR_EN adds a wrapping accepted-instruction counter on instr_count.
module unidade_busca #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  output logic        erro,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    ENTREGA = 2'd1,
    ERRO    = 2'd2
  } estado_t;

  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

  estado_t     state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] tmo_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic        erro_q;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        taken;
  logic        accept;
  logic [31:0] next_pc_d;

  assign accept = (state_q == ENTREGA) && instr_ready;

  always_comb begin
    pc4       = pc_out_q + 32'd4;
    br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    taken     = Branch && (((instr_q[31:26] == OP_BEQ) && zero) ||
                           ((instr_q[31:26] == OP_BNE) && !zero));
    next_pc_d = pc4;
    if (Jump) begin
      next_pc_d = {pc4[31:28], instr_q[25:0], 2'b00};
    end else if (taken) begin
      next_pc_d = pc4 + br_off;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ESPERA;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      pc_out_q      <= '0;
      tmo_q         <= '0;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
      erro_q        <= 1'b0;
    end else begin
      case (state_q)
        ESPERA: begin
          // an ack in the last allowed cycle takes priority over the timeout
          if (imem_ack) begin
            instr_q       <= imem_data;
            pc_out_q      <= pc_q;
            state_q       <= ENTREGA;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
            state_q    <= ERRO;
            imem_req_q <= 1'b0;
            erro_q     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        ENTREGA: begin
          if (instr_ready) begin
            pc_q          <= next_pc_d;
            tmo_q         <= '0;
            state_q       <= ESPERA;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        ERRO: begin
          state_q <= ERRO;
        end
        default: begin
          state_q       <= ERRO;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          erro_q        <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = instr_valid_q;
  assign erro        = erro_q;

`ifdef BUSCA_CONTADOR_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign instr_count = cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign instr_count   = '0;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca: table of next-PC vectors plus hand sequences for backpressure and timeout.
module tb_unidade_busca;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        Branch;
  logic        Jump;
  logic        zero;
  logic        erro;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;

  always #5 clock = ~clock;

  unidade_busca #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Branch      (Branch),
    .Jump        (Jump),
    .zero        (zero),
    .erro        (erro),
    .instr_count (instr_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        br;
    logic        jp;
    logic        zr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    imem_ack    = 1'b1;
    imem_data   = 32'hDEAD_BEEF;
    instr_ready = 1'b1;
    Jump        = 1'b1;
    Branch      = 1'b1;
    zero        = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset       = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    Jump        = 1'b0;
    Branch      = 1'b0;
    zero        = 1'b0;
    n_acc       = 0;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    chk("rst_count", instr_count, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] w, input logic [31:0] p);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, p);
    imem_ack  = 1'b1;
    imem_data = w;
    @(negedge clock);
    imem_ack  = 1'b0;
    imem_data = $urandom;
    chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("fetch_req_low", {31'd0, imem_req}, 32'd0);
    chk("fetch_instr", instr, w);
    chk("fetch_pc_out", pc_out, p);
  endtask

  task automatic accept(input logic b, input logic j, input logic z, input logic [31:0] exp);
    instr_ready = 1'b1;
    Branch      = b;
    Jump        = j;
    zero        = z;
    @(negedge clock);
    instr_ready = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;
    zero        = 1'b0;
    n_acc++;
    chk("acc_valid", {31'd0, instr_valid}, 32'd0);
    chk("acc_req", {31'd0, imem_req}, 32'd1);
    chk("acc_next_pc", imem_addr, exp);
  endtask

  function automatic logic [31:0] exp_count();
`ifdef BUSCA_CONTADOR_EN
    return 32'(n_acc);
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    int n;
    logic [31:0] p;
    vecs[0] = '{32'h0000_0010, 32'h1000_0003, 1'b1, 1'b0, 1'b1, 32'h0000_0020};
    vecs[1] = '{32'h0000_0010, 32'h1400_0003, 1'b1, 1'b0, 1'b1, 32'h0000_0014};
    vecs[2] = '{32'h0000_0100, 32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
    vecs[3] = '{32'h0000_0010, 32'h1400_0003, 1'b1, 1'b0, 1'b0, 32'h0000_0020};
    vecs[4] = '{32'h0000_0010, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    vecs[5] = '{32'h0000_0040, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_003C};
    vecs[6] = '{32'h0000_0020, 32'h8C08_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0024};
    vecs[7] = '{32'h0000_0020, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 32'h0000_0024};
    vecs[8] = '{32'h0000_0030, 32'h1000_0010, 1'b1, 1'b1, 1'b1, 32'h0000_0040};
    vecs[9] = '{32'h0000_0010, 32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC};

    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_data   = 32'h0;
    instr_ready = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;
    zero        = 1'b0;
    do_reset();

    // two idle request cycles, ack on the third; valid only after the ack edge
    @(negedge clock);
    @(negedge clock);
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    imem_ack  = 1'b1;
    imem_data = 32'h8C08_0004;
    chk("valid_before_ack_edge", {31'd0, instr_valid}, 32'd0);
    @(negedge clock);
    imem_ack = 1'b0;
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", instr, 32'h8C08_0004);
    chk("first_pc_out", pc_out, 32'h0);
    accept(1'b0, 1'b0, 1'b0, 32'h4);

    // backpressure with stray acks and control inputs
    fetch(32'h2002_0005, 32'h4);
    for (int i = 0; i < 5; i++) begin
      imem_ack  = 1'b1;
      imem_data = 32'hA5A5_0000 + 32'(i);
      Jump      = i[0];
      Branch    = ~i[0];
      zero      = 1'b1;
      @(negedge clock);
      chk("bp_instr", instr, 32'h2002_0005);
      chk("bp_pc_out", pc_out, 32'h4);
      chk("bp_req", {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_addr", imem_addr, 32'h4);
    end
    imem_ack = 1'b0;
    accept(1'b0, 1'b0, 1'b0, 32'h8);
    p = 32'h8;

    for (int i = 0; i < 10; i++) begin
      fetch({6'b000010, vecs[i].pc[27:2]}, p);
      accept(1'b0, 1'b1, 1'b0, vecs[i].pc);
      fetch(vecs[i].word, vecs[i].pc);
      accept(vecs[i].br, vecs[i].jp, vecs[i].zr, vecs[i].exp);
      p = vecs[i].exp;
    end

    // jump keeps the upper nibble of pc+4, which here has rolled into 4'h1
    fetch(32'h0800_0001, 32'h0FFF_FFFC);
    accept(1'b0, 1'b1, 1'b0, 32'h1000_0004);
    chk("count_after_table", instr_count, exp_count());

    n = 0;
    while (imem_req === 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_erro", {31'd0, erro}, 32'd1);
    chk("timeout_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack  = 1'b1;
    imem_data = 32'h1234_5678;
    @(negedge clock);
    @(negedge clock);
    imem_ack = 1'b0;
    chk("erro_sticky", {31'd0, erro}, 32'd1);
    chk("erro_req", {31'd0, imem_req}, 32'd0);
    chk("erro_valid", {31'd0, instr_valid}, 32'd0);

    do_reset();

    // ack on the last allowed cycle wins, twice to prove the counter restarts
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      chk("last_cycle_req", {31'd0, imem_req}, 32'd1);
      chk("last_cycle_erro", {31'd0, erro}, 32'd0);
      imem_ack  = 1'b1;
      imem_data = 32'h0000_1000 + 32'(k);
      @(negedge clock);
      imem_ack = 1'b0;
      chk("last_ack_valid", {31'd0, instr_valid}, 32'd1);
      chk("last_ack_erro", {31'd0, erro}, 32'd0);
      chk("last_ack_instr", instr, 32'h0000_1000 + 32'(k));
      accept(1'b0, 1'b0, 1'b0, 32'(4 * (k + 1)));
    end

    fetch(32'h0000_0000, 32'h8);
    accept(1'b0, 1'b0, 1'b0, 32'hC);
    chk("count_three", instr_count, exp_count());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter TIMEOUT_CYC, default 16: max cycles waiting for memory acknowledge; 0 disables the timeout.
REQ-003 clock  input  1  rising-edge clock, the only clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  byte address of requested word, always equal to the current PC.
REQ-007 imem_ack  input  1  memory data valid; considered only while imem_req=1.
REQ-008 imem_data  input  32  instruction word, valid with imem_ack.
REQ-009 instr  output  32  held instruction to decode stage; opcode = instr[31:26].
REQ-010 pc_out  output  32  PC of instr.
REQ-011 instr_valid  output  1  instr/pc_out valid to decode stage.
REQ-012 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-013 Branch, Jump  input  1 each  control-unit outputs for the instruction being accepted.
REQ-014 zero  input  1  ALU zero flag for the instruction being accepted.
REQ-015 erro  output  1  sticky fetch-timeout flag.
REQ-016 instr_count  output  32  accepted-instruction count (see Configuration).

Function
REQ-017 FSM states SHALL be ESPERA (imem_req=1), ENTREGA (instr_valid=1), ERRO (all handshakes low, erro=1).
REQ-018 ESPERA with imem_ack=1 SHALL latch imem_data into instr, imem_addr into pc_out, and move to ENTREGA; instr_valid rises the cycle after ack.
REQ-019 Accept = ENTREGA and instr_ready=1; on accept the PC SHALL take next_pc and the FSM SHALL return to ESPERA, so imem_req is low exactly on the accept cycle's successor boundary: no request is issued in ENTREGA.
REQ-020 next_pc SHALL be, in priority: Jump=1 -> {pc4[31:28], instr[25:0], 2'b00}; Branch=1 and taken -> pc4 + (sign-extended instr[15:0] << 2); else pc4; pc4 = pc_out + 4, all 32-bit wrap-around.
REQ-021 Branch taken SHALL be zero=1 when instr[31:26]=6'b000100 (BEQ), zero=0 when 6'b000101 (BNE); any other opcode with Branch=1 is not taken.
REQ-022 Branch, Jump, zero SHALL be ignored outside the accept cycle.
REQ-023 While ENTREGA without accept, instr, pc_out, imem_addr SHALL hold stable (backpressure).
REQ-024 imem_ack outside ESPERA SHALL be ignored.
REQ-025 Timeout counter SHALL clear on entry to ESPERA and count ESPERA cycles without ack; after TIMEOUT_CYC such cycles (TIMEOUT_CYC>0) the FSM SHALL enter ERRO; an ack in the last allowed cycle wins.
REQ-026 ERRO SHALL be left only by reset.
REQ-027 PC arithmetic SHALL not check alignment; imem_addr[1:0] follows next_pc.

Reset
REQ-028 On reset: state ESPERA, PC=RESET_PC, instr=0, pc_out=0, instr_valid=0, erro=0, timeout counter=0, instr_count=0; imem_req=1 in the first cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL override all inputs that cycle; an ack coincident with reset is discarded.

Configuration
REQ-030 Macro BUSCA_CONTADOR_EN defined: instr_count SHALL increment by 1 (wrapping) on every accept.
REQ-031 Macro BUSCA_CONTADOR_EN undefined: instr_count SHALL be constant 0 and no counter register exists.

Verification
REQ-032 Reset, ack 2 cycles after request with 32'h8C08_0004 -> imem_addr=0, instr_valid=1 one cycle after ack, pc_out=0; accept -> imem_addr=4.
REQ-033 instr 32'h1000_0003 at pc 0x10, Branch=1, zero=1 accepted -> imem_addr=0x20; same word opcode BNE (32'h1400_0003), zero=1 -> 0x14.
REQ-034 instr 32'h0800_0040 at pc 0x100, Jump=1 accepted -> imem_addr=0x100.
REQ-035 instr_ready=0 for 5 cycles in ENTREGA -> instr, pc_out unchanged, imem_req=0 throughout, ack pulses ignored.
REQ-036 TIMEOUT_CYC=4, no ack -> imem_req high exactly 4 cycles, then erro=1, imem_req=0; ack on 4th cycle -> ENTREGA, erro=0; reset clears erro.
REQ-037 With BUSCA_CONTADOR_EN, 3 accepts -> instr_count=3; without it -> instr_count=0.
